pelota: RTL and testbench



---
 rtl/pelota_pkg.sv | 23 ++
 rtl/pelota_if.sv | 40 ++++
 rtl/pelota_choque.sv | 38 +++
 rtl/pelota.sv | 229 ++++++++++++++++++++++
 tb/tb_pelota.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pelota_pkg.sv
// ---------------------------------------------------------------------------
// pelota_pkg
// Shared Pong definitions: court geometry constants and the ball-engine
// state encoding. Imported by the ball engine and the paddle hit detector.
// No ports.
// ---------------------------------------------------------------------------
package pelota_pkg;

    // Court geometry, in pixels.
    localparam int COURT_X_LEFT   = 40;
    localparam int COURT_X_RIGHT  = 600;
    localparam int COURT_Y_TOP    = 30;
    localparam int COURT_Y_BOTTOM = 389;
    localparam int COURT_PADDLE_H = 60;
    localparam int COURT_BALL     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } state_e;

endpackage

// File: rtl/pelota_if.sv
// ---------------------------------------------------------------------------
// pelota_if
// Bundle of the ball engine's frame/serve controls, paddle positions and
// ball/score outputs.
//   slave  : the ball engine (receives tick, serve, paddles; drives outputs)
//   master : the environment driving the engine and consuming its outputs
// Signals:
//   tick        frame strobe (one cycle)
//   serve       launch request
//   pad_left_y  left paddle top row  (10 bit)
//   pad_right_y right paddle top row (10 bit)
//   ball_x/y    ball top-left corner (10 bit each)
//   score_left/right  points (4 bit each)
//   point       one-cycle pulse when a point is awarded
//   game_over   sticky end-of-game flag
// ---------------------------------------------------------------------------
interface pelota_if;

    logic       tick;
    logic       serve;
    logic [9:0] pad_left_y;
    logic [9:0] pad_right_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       point;
    logic       game_over;

    modport slave (
        input  tick, serve, pad_left_y, pad_right_y,
        output ball_x, ball_y, score_left, score_right, point, game_over
    );

    modport master (
        output tick, serve, pad_left_y, pad_right_y,
        input  ball_x, ball_y, score_left, score_right, point, game_over
    );

endinterface

// File: rtl/pelota_choque.sv
// ---------------------------------------------------------------------------
// choque
// Combinational paddle hit detector. The ball's vertical span
// [ball_y, ball_y+BALL-1] is compared against the paddle span
// [pad_y, pad_y+PADDLE_H-1]; any overlap, including a single shared row,
// counts as a hit.
// Ports:
//   ball_y_i  ball top row  (10 bit)
//   pad_y_i   paddle top row (10 bit)
//   hit_o     1 when the spans overlap
// ---------------------------------------------------------------------------
module choque
    import pelota_pkg::*;
#(
    parameter int BALL     = COURT_BALL,
    parameter int PADDLE_H = COURT_PADDLE_H
) (
    input  logic [9:0] ball_y_i,
    input  logic [9:0] pad_y_i,
    output logic       hit_o
);

    localparam logic signed [11:0] S_BALL_M1 = 12'(BALL - 1);
    localparam logic signed [11:0] S_PAD_M1  = 12'(PADDLE_H - 1);

    logic signed [11:0] ball_top_s;
    logic signed [11:0] ball_bot_s;
    logic signed [11:0] pad_top_s;
    logic signed [11:0] pad_bot_s;

    assign ball_top_s = signed'({2'b00, ball_y_i});
    assign ball_bot_s = ball_top_s + S_BALL_M1;
    assign pad_top_s  = signed'({2'b00, pad_y_i});
    assign pad_bot_s  = pad_top_s + S_PAD_M1;

    assign hit_o = (ball_bot_s >= pad_top_s) && (ball_top_s <= pad_bot_s);

endmodule

// File: rtl/pelota.sv
// ---------------------------------------------------------------------------
// pelota
// Pong ball engine. Moves the ball once per frame tick, bounces it off the
// top/bottom walls and the paddles, awards points on misses, holds the ball
// for HOLD ticks after a point and then recenters it for the next serve.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    pelota_if.slave: tick, serve, paddle rows in; ball position,
//          scores, point pulse and game_over out (all registered)
// ---------------------------------------------------------------------------
module pelota
    import pelota_pkg::*;
#(
    parameter int X_LEFT   = COURT_X_LEFT,
    parameter int X_RIGHT  = COURT_X_RIGHT,
    parameter int Y_TOP    = COURT_Y_TOP,
    parameter int Y_BOTTOM = COURT_Y_BOTTOM,
    parameter int BALL     = COURT_BALL,
    parameter int PADDLE_H = COURT_PADDLE_H,
    parameter int STEP_X   = 4,
    parameter int STEP_Y   = 2,
    parameter int HOLD     = 60,
    parameter int X_CENTER = 316,
    parameter int Y_CENTER = 206,
    parameter int WIN      = 9
) (
    input  logic     clk,
    input  logic     reset,
    pelota_if.slave  bus
);

    localparam logic signed [11:0] S_X_LEFT   = 12'(X_LEFT);
    localparam logic signed [11:0] S_X_RIGHT  = 12'(X_RIGHT);
    localparam logic signed [11:0] S_Y_TOP    = 12'(Y_TOP);
    localparam logic signed [11:0] S_Y_BOTTOM = 12'(Y_BOTTOM);
    localparam logic signed [11:0] S_BALL_M1  = 12'(BALL - 1);
    localparam logic signed [11:0] S_STEP_X   = 12'(STEP_X);
    localparam logic signed [11:0] S_STEP_Y   = 12'(STEP_Y);

    localparam logic [9:0] X_CENTER_V = 10'(X_CENTER);
    localparam logic [9:0] Y_CENTER_V = 10'(Y_CENTER);
    localparam logic [9:0] X_LEFT_V   = 10'(X_LEFT);
    localparam logic [9:0] X_RIGHT_V  = 10'(X_RIGHT - BALL + 1);
    localparam logic [9:0] Y_TOP_V    = 10'(Y_TOP);
    localparam logic [9:0] Y_BOTTOM_V = 10'(Y_BOTTOM - BALL + 1);
    localparam logic [3:0] WIN_V      = 4'(WIN);
    localparam logic [7:0] HOLD_V     = 8'(HOLD);

    // Score increment that sticks at WIN.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        if (s >= WIN_V) return WIN_V;
        return s + 4'd1;
    endfunction

    state_e     state_q, state_d;
    logic [9:0] bx_q, bx_d;
    logic [9:0] by_q, by_d;
    logic       dx_q, dx_d;        // 1: moving right
    logic       dy_q, dy_d;        // 1: moving down
    logic [3:0] sl_q, sl_d;
    logic [3:0] sr_q, sr_d;
    logic       point_q, point_d;
    logic       go_q, go_d;
    logic [7:0] hold_q, hold_d;

    logic       hit_l, hit_r;
    logic [3:0] sl_inc, sr_inc;

    // Candidate next positions and wall-contact tests, all in 12-bit signed
    // so the "before the wall" subtractions cannot wrap.
    logic signed [11:0] bx_s, by_s;
    logic signed [11:0] y_up_s, y_dn_s, x_lt_s, x_rt_s;

    assign bx_s   = signed'({2'b00, bx_q});
    assign by_s   = signed'({2'b00, by_q});
    assign y_up_s = by_s - S_STEP_Y;
    assign y_dn_s = by_s + S_STEP_Y;
    assign x_lt_s = bx_s - S_STEP_X;
    assign x_rt_s = bx_s + S_STEP_X;

    assign sl_inc = sat_inc(sl_q);
    assign sr_inc = sat_inc(sr_q);

    // Hit tests use the pre-update ball_y.
    choque #(.BALL(BALL), .PADDLE_H(PADDLE_H)) u_choque_l (
        .ball_y_i (by_q),
        .pad_y_i  (bus.pad_left_y),
        .hit_o    (hit_l)
    );

    choque #(.BALL(BALL), .PADDLE_H(PADDLE_H)) u_choque_r (
        .ball_y_i (by_q),
        .pad_y_i  (bus.pad_right_y),
        .hit_o    (hit_r)
    );

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        point_d = 1'b0;
        go_d    = go_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                bx_d = X_CENTER_V;
                by_d = Y_CENTER_V;
                if (bus.serve && !go_q) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (bus.tick) begin
                    // Vertical motion with wall clamp and bounce.
                    if (!dy_q) begin
                        if (y_up_s <= S_Y_TOP) begin
                            by_d = Y_TOP_V;
                            dy_d = 1'b1;
                        end else begin
                            by_d = y_up_s[9:0];
                        end
                    end else begin
                        if (y_dn_s + S_BALL_M1 >= S_Y_BOTTOM) begin
                            by_d = Y_BOTTOM_V;
                            dy_d = 1'b0;
                        end else begin
                            by_d = y_dn_s[9:0];
                        end
                    end

                    // Horizontal motion; reaching a paddle face is a hit or
                    // a miss. A miss overrides the vertical update so the
                    // ball freezes where it was.
                    if (!dx_q && (x_lt_s <= S_X_LEFT)) begin
                        if (hit_l) begin
                            bx_d = X_LEFT_V;
                            dx_d = 1'b1;
                        end else begin
                            bx_d    = bx_q;
                            by_d    = by_q;
                            dy_d    = dy_q;
                            dx_d    = 1'b0;
                            sr_d    = sr_inc;
                            go_d    = go_q | (sr_inc == WIN_V);
                            point_d = 1'b1;
                            hold_d  = 8'd0;
                            state_d = SCORED;
                        end
                    end else if (dx_q && (x_rt_s + S_BALL_M1 >= S_X_RIGHT)) begin
                        if (hit_r) begin
                            bx_d = X_RIGHT_V;
                            dx_d = 1'b0;
                        end else begin
                            bx_d    = bx_q;
                            by_d    = by_q;
                            dy_d    = dy_q;
                            dx_d    = 1'b1;
                            sl_d    = sl_inc;
                            go_d    = go_q | (sl_inc == WIN_V);
                            point_d = 1'b1;
                            hold_d  = 8'd0;
                            state_d = SCORED;
                        end
                    end else if (dx_q) begin
                        bx_d = x_rt_s[9:0];
                    end else begin
                        bx_d = x_lt_s[9:0];
                    end
                end
            end

            SCORED: begin
                if (bus.tick) begin
                    hold_d = hold_q + 8'd1;
                    if (hold_d == HOLD_V) begin
                        bx_d    = X_CENTER_V;
                        by_d    = Y_CENTER_V;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bx_q    <= X_CENTER_V;
            by_q    <= Y_CENTER_V;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            point_q <= 1'b0;
            go_q    <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            point_q <= point_d;
            go_q    <= go_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.ball_x      = bx_q;
    assign bus.ball_y      = by_q;
    assign bus.score_left  = sl_q;
    assign bus.score_right = sr_q;
    assign bus.point       = point_q;
    assign bus.game_over   = go_q;

endmodule

// File: tb/tb_pelota.sv
// ---------------------------------------------------------------------------
// tb_pelota
// Self-checking bench for the pelota ball engine: a directed vector table,
// hand-written serve/bounce/miss/game-over/async-reset sequences, and a
// randomized run compared every cycle against a behavioural court model.
// ---------------------------------------------------------------------------
module tb_pelota;

    logic clk = 1'b0;
    logic reset;

    pelota_if bus ();

    pelota dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural court model: plain integers, direction as +1/-1,
    // "playing" flag and a countdown of ticks left in the post-point hold.
    int mx, my, mdx, mdy, msl, msr, mpt, mgo, mplay, mwait;

    function automatic bit overlap(input int y, input int p);
        return (y + 7 >= p) && (y <= p + 59);
    endfunction

    task automatic model_reset();
        mx = 316; my = 206; mdx = 1; mdy = 1;
        msl = 0; msr = 0; mpt = 0; mgo = 0; mplay = 0; mwait = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input int pl, input int pr);
        int  ny, ndy, nx, ndx;
        bit  miss;
        mpt = 0;
        if (mwait > 0) begin
            if (t) begin
                mwait--;
                if (mwait == 0) begin
                    mx = 316;
                    my = 206;
                end
            end
        end else if (!mplay) begin
            if (s && !mgo) mplay = 1;
        end else if (t) begin
            ny = my; ndy = mdy;
            if (mdy < 0) begin
                if (my - 2 <= 30) begin ny = 30; ndy = 1; end
                else ny = my - 2;
            end else begin
                if (my + 7 + 2 >= 389) begin ny = 382; ndy = -1; end
                else ny = my + 2;
            end
            miss = 0; nx = mx; ndx = mdx;
            if (mdx < 0 && mx - 4 <= 40) begin
                if (overlap(my, pl)) begin nx = 40; ndx = 1; end
                else begin
                    miss = 1;
                    if (msr < 9) msr++;
                    if (msr == 9) mgo = 1;
                    mdx = -1;
                end
            end else if (mdx > 0 && mx + 7 + 4 >= 600) begin
                if (overlap(my, pr)) begin nx = 593; ndx = -1; end
                else begin
                    miss = 1;
                    if (msl < 9) msl++;
                    if (msl == 9) mgo = 1;
                    mdx = 1;
                end
            end else begin
                nx = mx + 4 * mdx;
            end
            if (miss) begin
                mplay = 0;
                mwait = 60;
                mpt   = 1;
            end else begin
                mx = nx; my = ny; mdx = ndx; mdy = ndy;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        checks++;
        if (bus.ball_x !== 10'(mx) || bus.ball_y !== 10'(my) ||
            bus.score_left !== 4'(msl) || bus.score_right !== 4'(msr) ||
            bus.point !== 1'(mpt) || bus.game_over !== 1'(mgo)) begin
            errors++;
            $display("FAIL model_%s actual x=%0d y=%0d sl=%0d sr=%0d pt=%0d go=%0d required x=%0d y=%0d sl=%0d sr=%0d pt=%0d go=%0d",
                     tag, bus.ball_x, bus.ball_y, bus.score_left, bus.score_right,
                     bus.point, bus.game_over, mx, my, msl, msr, mpt, mgo);
        end
    endtask

    // One clock: inputs applied before the edge, model advanced on the edge,
    // DUT sampled 1 ns after it.
    task automatic cyc(input bit t, input bit s, input string tag);
        bus.tick  = t;
        bus.serve = s;
        @(posedge clk);
        if (!reset) model_step(t, s, int'(bus.pad_left_y), int'(bus.pad_right_y));
        #1;
        cmp_model(tag);
        bus.tick  = 1'b0;
        bus.serve = 1'b0;
    endtask

    task automatic do_reset();
        bus.tick  = 1'b0;
        bus.serve = 1'b0;
        reset     = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},  32'(bus.ball_x), 32'd316);
        chk({tag, "_y"},  32'(bus.ball_y), 32'd206);
        chk({tag, "_sl"}, 32'(bus.score_left), 32'd0);
        chk({tag, "_sr"}, 32'(bus.score_right), 32'd0);
        chk({tag, "_pt"}, 32'(bus.point), 32'd0);
        chk({tag, "_go"}, 32'(bus.game_over), 32'd0);
    endtask

    typedef struct {
        bit t;
        bit s;
        int ex;
        int ey;
    } vec_t;

    vec_t vt[9];

    initial begin
        bit got;

        reset           = 1'b1;
        bus.tick        = 1'b0;
        bus.serve       = 1'b0;
        bus.pad_left_y  = 10'd300;
        bus.pad_right_y = 10'd300;
        model_reset();
        #12;
        do_reset();
        chk_reset_vals("reset");

        // Idle ticks, serve coinciding with tick, first moves.
        vt[0] = '{1, 0, 316, 206};
        vt[1] = '{1, 0, 316, 206};
        vt[2] = '{1, 0, 316, 206};
        vt[3] = '{1, 0, 316, 206};
        vt[4] = '{1, 0, 316, 206};
        vt[5] = '{1, 1, 316, 206};
        vt[6] = '{1, 0, 320, 208};
        vt[7] = '{0, 0, 320, 208};
        vt[8] = '{1, 0, 324, 210};
        for (int i = 0; i < 9; i++) begin
            cyc(vt[i].t, vt[i].s, "table");
            chk($sformatf("table%0d_x", i), 32'(bus.ball_x), 32'(vt[i].ex));
            chk($sformatf("table%0d_y", i), 32'(bus.ball_y), 32'(vt[i].ey));
            chk($sformatf("table%0d_pt", i), 32'(bus.point), 32'd0);
        end

        // Right-paddle hit on tick 70, bottom-wall bounce on tick 88.
        for (int k = 3; k <= 89; k++) begin
            cyc(1, 0, "bounce");
            if (k == 70) chk("rhit_x", 32'(bus.ball_x), 32'd593);
            if (k == 71) chk("rhit_next_x", 32'(bus.ball_x), 32'd589);
            if (k == 88) chk("bwall_y", 32'(bus.ball_y), 32'd382);
            if (k == 89) chk("bwall_next_y", 32'(bus.ball_y), 32'd380);
        end
        chk("bounce_sl", 32'(bus.score_left), 32'd0);

        // Same path with the right paddle at the top: miss on tick 70.
        do_reset();
        bus.pad_right_y = 10'd30;
        cyc(0, 1, "serve");
        for (int k = 1; k <= 70; k++) begin
            cyc(1, 0, "miss");
            if (k == 69) chk("pre_miss_pt", 32'(bus.point), 32'd0);
            if (k == 70) begin
                chk("miss_pt", 32'(bus.point), 32'd1);
                chk("miss_sl", 32'(bus.score_left), 32'd1);
                chk("miss_freeze_x", 32'(bus.ball_x), 32'd592);
                chk("miss_freeze_y", 32'(bus.ball_y), 32'd344);
            end
        end
        cyc(0, 0, "miss");
        chk("pt_one_cycle", 32'(bus.point), 32'd0);
        for (int k = 1; k <= 60; k++) begin
            cyc(1, 0, "hold");
            if (k == 59) chk("hold59_x", 32'(bus.ball_x), 32'd592);
            if (k == 60) begin
                chk("hold60_x", 32'(bus.ball_x), 32'd316);
                chk("hold60_y", 32'(bus.ball_y), 32'd206);
            end
        end
        cyc(0, 1, "reserve");
        cyc(1, 0, "reserve");
        chk("reserve_x", 32'(bus.ball_x), 32'd320);

        // Keep missing until the left player reaches WIN.
        for (int r = 0; r < 12 && bus.score_left != 4'd9; r++) begin
            got = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                cyc(1, 0, "rounds");
                got = bus.point;
            end
            chk("round_point_seen", 32'(got), 32'd1);
            for (int k = 0; k < 60; k++) cyc(1, 0, "rounds");
            cyc(0, 1, "rounds");
        end
        chk("win_sl", 32'(bus.score_left), 32'd9);
        chk("win_sr", 32'(bus.score_right), 32'd0);
        chk("win_go", 32'(bus.game_over), 32'd1);
        cyc(0, 1, "over");
        cyc(1, 0, "over");
        cyc(1, 1, "over");
        cyc(1, 0, "over");
        chk("over_x", 32'(bus.ball_x), 32'd316);
        chk("over_y", 32'(bus.ball_y), 32'd206);
        chk("over_sl", 32'(bus.score_left), 32'd9);
        chk("over_go", 32'(bus.game_over), 32'd1);

        // Asynchronous reset mid-PLAY, checked before the next clock edge.
        do_reset();
        cyc(0, 1, "async");
        for (int k = 0; k < 10; k++) cyc(1, 0, "async");
        chk("async_pre_x", 32'(bus.ball_x), 32'd356);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_reset_vals("async_play");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Asynchronous reset mid-SCORED clears the awarded point.
        bus.pad_right_y = 10'd30;
        cyc(0, 1, "async2");
        for (int k = 0; k < 72; k++) cyc(1, 0, "async2");
        chk("async2_pre_sl", 32'(bus.score_left), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_reset_vals("async_scored");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized play against the model.
        for (int i = 0; i < 8000; i++) begin
            if (i == 4000) do_reset();
            bus.pad_left_y  = 10'($urandom_range(30, 329));
            bus.pad_right_y = 10'($urandom_range(30, 329));
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
